complete_arbiter: RTL and testbench



---
 rtl/complete_arbiter_pkg.sv | 18 +
 rtl/complete_arbiter_if.sv | 33 +++
 rtl/complete_arbiter_rr_picker.sv | 49 ++++
 rtl/complete_arbiter.sv | 124 ++++++++++++
 tb/tb_complete_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/complete_arbiter_pkg.sv
// Shared defaults and helpers for the CDB completion arbiter.
// FU bit order across the CDB grant bus: ALU low, then MULT, BRANCH, LDST.
package complete_arbiter_pkg;

   localparam int unsigned DEF_N             = 3;
   localparam int unsigned DEF_NUM_FU_ALU    = 3;
   localparam int unsigned DEF_NUM_FU_MULT   = 2;
   localparam int unsigned DEF_NUM_FU_BRANCH = 1;
   localparam int unsigned DEF_NUM_FU_LDST   = 1;
   localparam int unsigned DEF_NUM_FU_TOTAL  = DEF_NUM_FU_ALU + DEF_NUM_FU_MULT +
                                               DEF_NUM_FU_BRANCH + DEF_NUM_FU_LDST;

   // Pointer width for a ring; a one-entry ring still carries a 1-bit pointer.
   function automatic int unsigned ptr_width(input int unsigned ring);
      return (ring > 1) ? $clog2(ring) : 1;
   endfunction

endpackage

// File: rtl/complete_arbiter_if.sv
// Issue/execute <-> completion arbiter signal bundle.
interface complete_arbiter_if
   import complete_arbiter_pkg::*;
#(
   parameter int unsigned N             = DEF_N,
   parameter int unsigned NUM_FU_ALU    = DEF_NUM_FU_ALU,
   parameter int unsigned NUM_FU_MULT   = DEF_NUM_FU_MULT,
   parameter int unsigned NUM_FU_BRANCH = DEF_NUM_FU_BRANCH,
   parameter int unsigned NUM_FU_LDST   = DEF_NUM_FU_LDST,
   parameter int unsigned NUM_FU_TOTAL  = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_BRANCH + NUM_FU_LDST
);
   localparam int unsigned SAW = $clog2(N + 1);

   logic [NUM_FU_ALU-1:0]                alu_req;
   logic [NUM_FU_BRANCH-1:0]             branch_req;
   logic [NUM_FU_MULT-1:0]               mult_cdb_valid;
   logic [NUM_FU_LDST-1:0]               ldst_cdb_valid;
   logic [NUM_FU_MULT-1:0]               mult_cdb_en;
   logic [NUM_FU_LDST-1:0]               ldst_cdb_en;
   logic [N-1:0][NUM_FU_TOTAL-1:0]       complete_gnt_bus;
   logic [SAW-1:0]                       sc_slots_avail;

   modport master (
      output alu_req, branch_req, mult_cdb_valid, ldst_cdb_valid,
      input  mult_cdb_en, ldst_cdb_en, complete_gnt_bus, sc_slots_avail
   );

   modport slave (
      input  alu_req, branch_req, mult_cdb_valid, ldst_cdb_valid,
      output mult_cdb_en, ldst_cdb_en, complete_gnt_bus, sc_slots_avail
   );

endinterface

// File: rtl/complete_arbiter_rr_picker.sv
// Round-robin picker: grants up to max_gnt requests in ring order from ptr,
// and returns the pointer one past the last grant (unchanged if none).
module rr_picker
   import complete_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned MAXGNT = 1,
   localparam int unsigned PW    = ptr_width(WIDTH),
   localparam int unsigned CW    = $clog2(MAXGNT + 1)
) (
   input  logic [WIDTH-1:0] req,
   input  logic [PW-1:0]    ptr,
   input  logic [CW-1:0]    max_gnt,
   output logic [WIDTH-1:0] gnt,
   output logic [PW-1:0]    next_ptr
);

   int unsigned start;
   int unsigned pos;
   int unsigned cnt;
   int unsigned last;
   int unsigned nxt;
   logic        any;

   always_comb begin
      gnt   = '0;
      cnt   = 0;
      last  = 0;
      nxt   = 0;
      any   = 1'b0;
      start = 32'(ptr);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         pos = start + i;
         if (pos >= WIDTH) pos = pos - WIDTH;
         for (int unsigned j = 0; j < WIDTH; j++) begin
            if (pos == j && req[j] && cnt < 32'(max_gnt)) begin
               gnt[j] = 1'b1;
               cnt    = cnt + 1;
               last   = j;
               any    = 1'b1;
            end
         end
      end
      nxt = last + 1;
      if (nxt >= WIDTH) nxt = 0;
      next_ptr = any ? PW'(nxt) : ptr;
   end

endmodule

// File: rtl/complete_arbiter.sv
// Per-cycle CDB slot allocator: reserves slots for multi-cycle FUs one cycle
// ahead, then fills the remaining rows with single-cycle requesters.
module complete_arbiter
   import complete_arbiter_pkg::*;
#(
   parameter int unsigned N             = DEF_N,
   parameter int unsigned NUM_FU_ALU    = DEF_NUM_FU_ALU,
   parameter int unsigned NUM_FU_MULT   = DEF_NUM_FU_MULT,
   parameter int unsigned NUM_FU_BRANCH = DEF_NUM_FU_BRANCH,
   parameter int unsigned NUM_FU_LDST   = DEF_NUM_FU_LDST,
   parameter int unsigned NUM_FU_TOTAL  = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_BRANCH + NUM_FU_LDST
) (
   input  logic               clock,
   input  logic               reset,
   complete_arbiter_if.slave  arb
);

   localparam int unsigned ALU_BASE    = 0;
   localparam int unsigned MULT_BASE   = ALU_BASE + NUM_FU_ALU;
   localparam int unsigned BRANCH_BASE = MULT_BASE + NUM_FU_MULT;
   localparam int unsigned LDST_BASE   = BRANCH_BASE + NUM_FU_BRANCH;

   localparam int unsigned MCW  = NUM_FU_MULT + NUM_FU_LDST;
   localparam int unsigned SCW  = NUM_FU_ALU + NUM_FU_BRANCH;
   localparam int unsigned MCPW = ptr_width(MCW);
   localparam int unsigned SCPW = ptr_width(SCW);
   localparam int unsigned SAW  = $clog2(N + 1);

   typedef logic [$clog2(N)-1:0] mc_cap_t;
   typedef logic [SAW-1:0]       avail_t;

   logic [MCW-1:0]               mc_req, mc_gnt, res_q;
   logic [SCW-1:0]               sc_req, sc_gnt;
   logic [MCPW-1:0]              mc_ptr, mc_ptr_nxt;
   logic [SCPW-1:0]              sc_ptr, sc_ptr_nxt;
   avail_t                       sc_avail;
   logic [N-1:0][NUM_FU_TOTAL-1:0] gnt_bus;
   int unsigned                  k;
   int unsigned                  row;
   int unsigned                  pos;

   assign mc_req = {arb.ldst_cdb_valid, arb.mult_cdb_valid};
   assign sc_req = {arb.branch_req, arb.alu_req};

   // Cap at N-1 so at least one row always remains for single-cycle FUs.
   rr_picker #(.WIDTH(MCW), .MAXGNT(N - 1)) u_mc_pick (
      .req      (mc_req),
      .ptr      (mc_ptr),
      .max_gnt  (mc_cap_t'(N - 1)),
      .gnt      (mc_gnt),
      .next_ptr (mc_ptr_nxt)
   );

   rr_picker #(.WIDTH(SCW), .MAXGNT(N)) u_sc_pick (
      .req      (sc_req),
      .ptr      (sc_ptr),
      .max_gnt  (sc_avail),
      .gnt      (sc_gnt),
      .next_ptr (sc_ptr_nxt)
   );

   always_comb begin
      k = 0;
      for (int unsigned m = 0; m < MCW; m++) k = k + 32'(res_q[m]);
      sc_avail = avail_t'(N - k);
   end

   // Reserved FUs fill rows in ascending FU index, then single-cycle grants in ring order.
   always_comb begin
      gnt_bus = '0;
      row     = 0;
      pos     = 0;
      for (int unsigned m = 0; m < NUM_FU_MULT; m++) begin
         if (res_q[m]) begin
            for (int unsigned r = 0; r < N; r++)
               if (row == r) gnt_bus[r][MULT_BASE + m] = 1'b1;
            row = row + 1;
         end
      end
      for (int unsigned l = 0; l < NUM_FU_LDST; l++) begin
         if (res_q[NUM_FU_MULT + l]) begin
            for (int unsigned r = 0; r < N; r++)
               if (row == r) gnt_bus[r][LDST_BASE + l] = 1'b1;
            row = row + 1;
         end
      end
      for (int unsigned i = 0; i < SCW; i++) begin
         pos = 32'(sc_ptr) + i;
         if (pos >= SCW) pos = pos - SCW;
         for (int unsigned j = 0; j < NUM_FU_ALU; j++) begin
            if (pos == j && sc_gnt[j]) begin
               for (int unsigned r = 0; r < N; r++)
                  if (row == r) gnt_bus[r][ALU_BASE + j] = 1'b1;
               row = row + 1;
            end
         end
         for (int unsigned b = 0; b < NUM_FU_BRANCH; b++) begin
            if (pos == NUM_FU_ALU + b && sc_gnt[NUM_FU_ALU + b]) begin
               for (int unsigned r = 0; r < N; r++)
                  if (row == r) gnt_bus[r][BRANCH_BASE + b] = 1'b1;
               row = row + 1;
            end
         end
      end
   end

   assign arb.mult_cdb_en      = reset ? '0 : mc_gnt[NUM_FU_MULT-1:0];
   assign arb.ldst_cdb_en      = reset ? '0 : mc_gnt[MCW-1:NUM_FU_MULT];
   assign arb.complete_gnt_bus = reset ? '0 : gnt_bus;
   assign arb.sc_slots_avail   = reset ? '0 : sc_avail;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         res_q  <= '0;
         mc_ptr <= '0;
         sc_ptr <= '0;
      end else begin
         res_q  <= mc_gnt;
         mc_ptr <= mc_ptr_nxt;
         sc_ptr <= sc_ptr_nxt;
      end
   end

endmodule

// File: tb/tb_complete_arbiter.sv
// Self-checking bench for complete_arbiter: directed scenarios, then random
// traffic checked against a queue-based reference model of the slot rules.
module tb_complete_arbiter;
   import complete_arbiter_pkg::*;

   logic clock = 1'b0;
   logic reset;

   complete_arbiter_if #(.N(3), .NUM_FU_ALU(3), .NUM_FU_MULT(2), .NUM_FU_BRANCH(1),
                         .NUM_FU_LDST(1)) ifc ();

   complete_arbiter #(.N(3), .NUM_FU_ALU(3), .NUM_FU_MULT(2), .NUM_FU_BRANCH(1),
                      .NUM_FU_LDST(1)) dut (
      .clock (clock),
      .reset (reset),
      .arb   (ifc.slave)
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   // Model state: FU indices reserved for this cycle, and the two ring pointers.
   int m_res[$];
   int m_mc_ptr, m_sc_ptr;
   int nx_res[$];
   int nx_mc_ptr, nx_sc_ptr;

   logic [1:0]       e_mult;
   logic             e_ldst;
   logic [2:0][6:0]  e_bus;
   logic [1:0]       e_avail;

   logic [1:0]       o_mult;
   logic             o_ldst;
   logic [2:0][6:0]  o_bus;
   logic [1:0]       o_avail;

   int mc_fu[3] = '{3, 4, 6};
   int sc_fu[4] = '{0, 1, 2, 5};
   int row2_seq[5] = '{1, 2, 4, 32, 1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_res.delete();
      m_mc_ptr = 0;
      m_sc_ptr = 0;
   endfunction

   function automatic void model_eval();
      bit vld[3];
      bit rq[4];
      int g, avail, pos, last, row, fu;
      vld = '{ifc.mult_cdb_valid[0], ifc.mult_cdb_valid[1], ifc.ldst_cdb_valid[0]};
      rq  = '{ifc.alu_req[0], ifc.alu_req[1], ifc.alu_req[2], ifc.branch_req[0]};
      e_mult  = '0;
      e_ldst  = 1'b0;
      e_bus   = '0;
      e_avail = '0;
      nx_res.delete();
      if (reset) begin
         nx_mc_ptr = 0;
         nx_sc_ptr = 0;
         return;
      end
      g = 0; last = -1;
      for (int k = 0; k < 3; k++) begin
         pos = (m_mc_ptr + k) % 3;
         if (vld[pos] && g < 2) begin
            g++;
            last = pos;
            nx_res.push_back(mc_fu[pos]);
            if (pos < 2) e_mult[pos] = 1'b1;
            else         e_ldst      = 1'b1;
         end
      end
      nx_res.sort();
      nx_mc_ptr = (last < 0) ? m_mc_ptr : (last + 1) % 3;

      avail   = 3 - m_res.size();
      e_avail = avail[1:0];
      row = 0;
      foreach (m_res[i]) begin
         fu = m_res[i];
         e_bus[row[1:0]][fu[2:0]] = 1'b1;
         row++;
      end
      g = 0; last = -1;
      for (int k = 0; k < 4; k++) begin
         pos = (m_sc_ptr + k) % 4;
         if (rq[pos] && g < avail) begin
            fu = sc_fu[pos];
            e_bus[row[1:0]][fu[2:0]] = 1'b1;
            row++;
            g++;
            last = pos;
         end
      end
      nx_sc_ptr = (last < 0) ? m_sc_ptr : (last + 1) % 4;
   endfunction

   task automatic set_reset(input logic v);
      reset = v;
      if (v) model_reset();
   endtask

   task automatic drive(input logic [2:0] alu, input logic br, input logic [1:0] mult,
                        input logic ldst);
      ifc.alu_req        = alu;
      ifc.branch_req     = br;
      ifc.mult_cdb_valid = mult;
      ifc.ldst_cdb_valid = ldst;
   endtask

   task automatic cycle();
      @(negedge clock);
      model_eval();
      o_mult  = ifc.mult_cdb_en;
      o_ldst  = ifc.ldst_cdb_en;
      o_bus   = ifc.complete_gnt_bus;
      o_avail = ifc.sc_slots_avail;
      chk("mult_cdb_en", 32'(o_mult), 32'(e_mult));
      chk("ldst_cdb_en", 32'(o_ldst), 32'(e_ldst));
      chk("gnt_bus", 32'(o_bus), 32'(e_bus));
      chk("sc_slots_avail", 32'(o_avail), 32'(e_avail));
      chk("mc_ptr", 32'(dut.mc_ptr), 32'(m_mc_ptr));
      chk("sc_ptr", 32'(dut.sc_ptr), 32'(m_sc_ptr));
      @(posedge clock);
      m_res     = nx_res;
      m_mc_ptr  = nx_mc_ptr;
      m_sc_ptr  = nx_sc_ptr;
      #1;
   endtask

   task automatic mid_reset_pulse();
      set_reset(1'b1);
      #2;
      chk("reset_gnt_bus", 32'(ifc.complete_gnt_bus), 32'h0);
      set_reset(1'b0);
      #1;
   endtask

   initial begin
      model_reset();
      reset = 1'b1;
      drive(3'b111, 1'b1, 2'b11, 1'b1);

      // Reset held with every requester high.
      repeat (2) cycle();
      chk("reset_slots", 32'(o_avail), 32'h0);
      chk("reset_mult_en", 32'(o_mult), 32'h0);

      // Release with all ALUs requesting.
      set_reset(1'b0);
      drive(3'b111, 1'b0, 2'b00, 1'b0);
      cycle();
      chk("release_rows", 32'(o_bus), 32'({7'b0000100, 7'b0000010, 7'b0000001}));
      chk("release_slots", 32'(o_avail), 32'd3);
      chk("release_sc_ptr", 32'(dut.sc_ptr), 32'd3);

      // Multi-cycle cap at N-1, then ldst granted first.
      drive(3'b000, 1'b0, 2'b11, 1'b1);
      cycle();
      chk("cap_mult_en", 32'(o_mult), 32'd3);
      chk("cap_ldst_en", 32'(o_ldst), 32'd0);
      cycle();
      chk("cap_row0", 32'(o_bus[0]), 32'd8);
      chk("cap_row1", 32'(o_bus[1]), 32'd16);
      chk("cap_slots", 32'(o_avail), 32'd1);
      chk("cap_ldst_first", 32'(o_ldst), 32'd1);

      // Single-cycle fairness with two rows reserved each cycle.
      mid_reset_pulse();
      drive(3'b000, 1'b0, 2'b11, 1'b0);
      cycle();
      drive(3'b111, 1'b1, 2'b11, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("fair_row2", 32'(o_bus[2]), 32'(row2_seq[i]));
      end

      // Reservation dropped by a reset between grant and completion.
      drive(3'b000, 1'b0, 2'b01, 1'b0);
      cycle();
      mid_reset_pulse();
      drive(3'b000, 1'b0, 2'b01, 1'b0);
      cycle();
      chk("rst_mid_en", 32'(o_mult), 32'd1);
      mid_reset_pulse();
      drive(3'b111, 1'b0, 2'b00, 1'b0);
      cycle();
      chk("rst_mid_nobit3", 32'(o_bus[0][3] | o_bus[1][3] | o_bus[2][3]), 32'd0);
      chk("rst_mid_slots", 32'(o_avail), 32'd3);

      // A reservation always completes the following cycle.
      drive(3'b000, 1'b0, 2'b10, 1'b0);
      cycle();
      chk("mispred_en", 32'(o_mult), 32'd2);
      drive(3'b111, 1'b1, 2'b00, 1'b0);
      cycle();
      chk("mispred_row0", 32'(o_bus[0]), 32'b0010000);

      // Idle: nothing granted, pointers hold.
      drive(3'b000, 1'b0, 2'b00, 1'b0);
      cycle();
      begin
         int p_mc, p_sc;
         p_mc = m_mc_ptr;
         p_sc = m_sc_ptr;
         for (int i = 0; i < 3; i++) begin
            cycle();
            chk("idle_bus", 32'(o_bus), 32'h0);
            chk("idle_slots", 32'(o_avail), 32'd3);
         end
         chk("idle_mc_ptr", 32'(dut.mc_ptr), 32'(p_mc));
         chk("idle_sc_ptr", 32'(dut.sc_ptr), 32'(p_sc));
      end

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         drive(3'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
         if ($urandom_range(0, 39) == 0) mid_reset_pulse();
         if ($urandom_range(0, 59) == 0) set_reset(1'b1);
         else                            set_reset(1'b0);
         cycle();
      end
      set_reset(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
